pattern_count_buffer: RTL and testbench

//  Per-pattern photon-count frame buffer for single-pixel imaging. Samples the

---
 rtl/pattern_count_buffer_if.sv | 11 +
 rtl/pattern_count_buffer.sv | 137 +++++++++++++
 tb/tb_pattern_count_buffer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pattern_count_buffer_if.sv
// pattern_count_buffer_if: valid/ready read stream carrying stored count words
interface pattern_count_buffer_if #(
  parameter int DATA_W = 16
);
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/pattern_count_buffer.sv
// pattern_count_buffer: per-pattern photon-count frame RAM with DMD-sync capture and drain stream
module pattern_count_buffer #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int SYNC_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dmd_sig,
  input  logic [DATA_W-1:0]     count_in,
  input  logic                  arm,
  input  logic                  stop,
  input  logic [ADDR_W:0]       frame_len,
  pattern_count_buffer_if.master rd,
  output logic [ADDR_W:0]       wr_count,
  output logic                  busy,
  output logic                  missed
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ACQ, DRAIN} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [ADDR_W:0] len_q, len_d, wr_count_q, wr_count_d, rd_addr_q, rd_addr_d;
  logic [ADDR_W:0] len_in, wr_inc, rd_inc;
  logic [ADDR_W-1:0] wr_addr;
  logic cap_q, cap_d, missed_q, missed_d;
  logic ram_v_q, ram_v_d, ram_last_q, ram_last_d;
  logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, ram_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic rise, fall, wr_en, rd_en, adv;
  assign rise    = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  assign fall    = ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
  assign len_in  = (frame_len == '0 || frame_len > DEPTH_L) ? DEPTH_L : frame_len;
  assign wr_inc  = wr_count_q + 1'b1;
  assign rd_inc  = rd_addr_q + 1'b1;
  assign wr_addr = arm ? '0 : wr_count_q[ADDR_W-1:0];
  // RAM stage and output register advance together; a stalled output freezes both
  assign adv     = ~rd_valid_q | rd.rd_ready;
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_count_d = wr_count_q;
    rd_addr_d  = rd_addr_q;
    cap_d      = cap_q;
    missed_d   = missed_q;
    ram_v_d    = ram_v_q;
    ram_last_d = ram_last_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        rd_addr_d  = '0;
        ram_v_d    = 1'b0;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        missed_d   = missed_q | rise;
      end
      ACQ: begin
        rd_addr_d = '0;
        wr_en     = rise;
        cap_d     = cap_q | rise;
        if (fall && cap_q) begin
          wr_count_d = wr_inc;
          cap_d      = 1'b0;
        end
        if (stop || (fall && cap_q && wr_inc == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        missed_d = missed_q | rise;
        if (adv) begin
          rd_valid_d = ram_v_q;
          rd_last_d  = ram_last_q;
          rd_data_d  = ram_v_q ? ram_q : rd_data_q;
          rd_en      = rd_addr_q < wr_count_q;
          ram_v_d    = rd_en;
          ram_last_d = rd_inc == wr_count_q;
          rd_addr_d  = rd_en ? rd_inc : rd_addr_q;
        end
        if ((rd_valid_q && rd.rd_ready && rd_last_q) || wr_count_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // arm restarts from IDLE or ACQ; a rise in the same cycle becomes pattern 0
    if (arm && state_q != DRAIN) begin
      state_d    = ACQ;
      len_d      = len_in;
      wr_count_d = '0;
      missed_d   = 1'b0;
      cap_d      = rise;
      wr_en      = rise;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      len_q      <= '0;
      wr_count_q <= '0;
      rd_addr_q  <= '0;
      cap_q      <= 1'b0;
      missed_q   <= 1'b0;
      ram_v_q    <= 1'b0;
      ram_last_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], dmd_sig};
      len_q      <= len_d;
      wr_count_q <= wr_count_d;
      rd_addr_q  <= rd_addr_d;
      cap_q      <= cap_d;
      missed_q   <= missed_d;
      ram_v_q    <= ram_v_d;
      ram_last_q <= ram_last_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= count_in;
    if (rd_en) ram_q <= mem[rd_addr_q[ADDR_W-1:0]];
  end
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;
  assign rd.rd_last  = rd_last_q;
  assign wr_count    = wr_count_q;
  assign busy        = state_q != IDLE;
  assign missed      = missed_q;
endmodule

// File: tb/tb_pattern_count_buffer.sv
// tb_pattern_count_buffer: directed frame vectors plus reset, missed and arm/rise corner sequences
module tb_pattern_count_buffer;
  localparam int DW = 16;
  localparam int D  = 8;
  localparam int AW = 3;
  logic clk = 1'b0, rst_n = 1'b0, dmd_sig = 1'b0, arm = 1'b0, stop = 1'b0;
  logic [DW-1:0] count_in = '0;
  logic [AW:0] frame_len = '0;
  logic [AW:0] wr_count;
  logic busy, missed;
  int checks = 0, errors = 0;
  pattern_count_buffer_if #(.DATA_W(DW)) rd_if ();
  pattern_count_buffer #(.DATA_W(DW), .DEPTH(D), .SYNC_STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n), .dmd_sig(dmd_sig), .count_in(count_in), .arm(arm), .stop(stop),
    .frame_len(frame_len), .rd(rd_if), .wr_count(wr_count), .busy(busy), .missed(missed)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [AW:0]   len;
    int            np;
    int            stop_mode;
    logic [DW-1:0] base;
    logic [DW-1:0] step;
    bit            toggle;
    int            exp;
  } vec_t;
  vec_t v [7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_arm(input logic [AW:0] len);
    frame_len = len;
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask
  task automatic do_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask
  task automatic pulse(input logic [DW-1:0] val);
    count_in = val;
    dmd_sig = 1'b1;
    cyc(5);
    dmd_sig = 1'b0;
    cyc(5);
  endtask
  task automatic drain(input int n, input logic [DW-1:0] base, input logic [DW-1:0] step, input bit toggle);
    int idx = 0;
    int c = 0;
    bit stalled = 1'b0;
    bit seen = 1'b0;
    logic [DW-1:0] pd;
    logic pl;
    while (idx < n && c < 200) begin
      rd_if.rd_ready = toggle ? (c % 3 == 0) : 1'b1;
      if (stalled) begin
        chk("stall_valid", rd_if.rd_valid, 1);
        chk("stall_data", rd_if.rd_data, pd);
        chk("stall_last", rd_if.rd_last, pl);
      end
      stalled = rd_if.rd_valid && !rd_if.rd_ready;
      pd = rd_if.rd_data;
      pl = rd_if.rd_last;
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        chk("data", rd_if.rd_data, 32'(16'(base + step * idx)));
        chk("last", rd_if.rd_last, 32'(idx == n - 1));
        idx++;
      end
      cyc(1);
      c++;
    end
    if (idx < n) chk("drain_timeout", idx, n);
    rd_if.rd_ready = 1'b0;
    repeat (4) begin
      if (rd_if.rd_valid) seen = 1'b1;
      cyc(1);
    end
    chk("post_valid", seen, 0);
    chk("post_busy", busy, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    v[0] = '{len: 4, np: 4, stop_mode: 0, base: 10,       step: 10,   toggle: 0, exp: 4};
    v[1] = '{len: 0, np: 8, stop_mode: 0, base: 1,        step: 1,    toggle: 0, exp: 8};
    v[2] = '{len: 6, np: 3, stop_mode: 2, base: 5,        step: 3,    toggle: 0, exp: 3};
    v[3] = '{len: 5, np: 5, stop_mode: 0, base: 100,      step: 7,    toggle: 1, exp: 5};
    v[4] = '{len: 9, np: 8, stop_mode: 0, base: 200,      step: 1,    toggle: 1, exp: 8};
    v[5] = '{len: 1, np: 1, stop_mode: 0, base: 16'hFFFF, step: 0,    toggle: 0, exp: 1};
    v[6] = '{len: 5, np: 2, stop_mode: 1, base: 3000,     step: 1000, toggle: 1, exp: 2};
    rd_if.rd_ready = 1'b0;
    cyc(2);
    chk("rst_valid", rd_if.rd_valid, 0);
    chk("rst_last", rd_if.rd_last, 0);
    chk("rst_data", rd_if.rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_missed", missed, 0);
    chk("rst_count", wr_count, 0);
    rst_n = 1'b1;
    cyc(2);
    pulse(16'h1);
    chk("idle_missed", missed, 1);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 7; i++) begin
      do_arm(v[i].len);
      chk("arm_busy", busy, 1);
      chk("arm_count", wr_count, 0);
      chk("arm_missed", missed, 0);
      for (int k = 0; k < v[i].np; k++) pulse(16'(v[i].base + v[i].step * k));
      if (v[i].stop_mode == 2) begin
        count_in = 16'hDEAD;
        dmd_sig = 1'b1;
        cyc(5);
        do_stop();
        dmd_sig = 1'b0;
      end else if (v[i].stop_mode == 1) do_stop();
      chk("frame_count", wr_count, v[i].exp);
      drain(v[i].exp, v[i].base, v[i].step, v[i].toggle);
      chk("frame_hold_count", wr_count, v[i].exp);
      chk("frame_missed", missed, 0);
    end
    do_arm(2);
    pulse(11);
    pulse(22);
    pulse(33);
    chk("drain_missed", missed, 1);
    chk("drain_busy", busy, 1);
    drain(2, 11, 11, 0);
    chk("drain_missed_sticky", missed, 1);
    do_arm(4);
    for (int k = 0; k < 4; k++) pulse(16'(k + 1));
    pulse(5);
    chk("pre_rst_missed", missed, 1);
    chk("pre_rst_valid", rd_if.rd_valid, 1);
    rd_if.rd_ready = 1'b1;
    cyc(1);
    rd_if.rd_ready = 1'b0;
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rd_if.rd_valid, 0);
    chk("mid_rst_last", rd_if.rd_last, 0);
    chk("mid_rst_data", rd_if.rd_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_missed", missed, 0);
    chk("mid_rst_count", wr_count, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    do_arm(2);
    pulse(7);
    pulse(9);
    chk("post_rst_count", wr_count, 2);
    drain(2, 7, 2, 0);
    chk("post_rst_missed", missed, 0);
    do_arm(2);
    pulse(50);
    chk("t6_first", wr_count, 1);
    count_in = 60;
    dmd_sig = 1'b1;
    cyc(2);
    frame_len = 2;
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
    chk("t6_restart", wr_count, 0);
    chk("t6_busy", busy, 1);
    cyc(3);
    dmd_sig = 1'b0;
    cyc(5);
    chk("t6_counted", wr_count, 1);
    pulse(70);
    chk("t6_done", wr_count, 2);
    drain(2, 60, 10, 0);
    chk("t6_missed", missed, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
